cart_ram_uploader: RTL and testbench
====================================

Name: cart_ram_uploader

Overview:
- Core-side responder for the HPS ioctl upload direction: the reader counterpart to the cartridge download writer path.
- On each HPS byte request it fetches the byte from the shared cartridge/work RAM through an arbitrated read port and presents it on ioctl_din.
- While a fetch is pending it stalls the HPS with ioctl_wait.
- Sits beside hps_io in the emu top; shares the RAM read port with the CPU, which has priority.

Parameters:
MEM_AW, 11, RAM address width in bytes.
MEM_SIZE, 2048, number of valid bytes; addresses >= MEM_SIZE are out of range.
UPLOAD_INDEX, 8'h01, ioctl_index value this block serves.
FILL, 8'hFF, byte returned for out-of-range addresses.

Ports:
clk_sys  in  1  system clock; all logic on rising edge.
reset_n  in  1  synchronous, active-low reset.
ioctl_upload  in  1  upload session active, from hps_io.
ioctl_index  in  8  selected file index.
ioctl_rd  in  1  one-cycle byte request strobe.
ioctl_addr  in  25  byte address of the request, valid with ioctl_rd.
ioctl_din  out  8  returned byte.
ioctl_wait  out  1  stall to hps_io; high while a fetch is pending.
mem_req  out  1  RAM read request; held until granted.
mem_addr  out  MEM_AW  RAM read address.
mem_gnt  in  1  arbiter grant; a request is accepted in a cycle where mem_req and mem_gnt are both high.
mem_q  in  8  RAM data, valid exactly one cycle after the accept cycle.
busy  out  1  FSM not in IDLE.
done  out  1  one-cycle pulse on the falling edge of an active session.
byte_count  out  25  bytes delivered this session.
checksum  out  8  wrapping 8-bit sum of delivered bytes this session.
proto_err  out  1  sticky; set when ioctl_rd arrives while busy.

Behaviour:
- Reset: the interface is one clock; reset is synchronous and active-low (reset_n).
- Reset values: all outputs 0 except ioctl_din=FILL. FSM=IDLE. Session flag=0.
- Reset mid-fetch: FSM returns to IDLE and mem_req drops on the next edge. Any grant arriving afterwards is ignored.
- Session:
  - active = ioctl_upload && ioctl_index==UPLOAD_INDEX.
  - Rising edge of active clears byte_count, checksum and proto_err.
  - Falling edge of active pulses done for one cycle.
  - Falling edge of active while busy aborts to IDLE (mem_req low, ioctl_wait low next cycle). The aborted byte is not counted.
- FSM states: IDLE, REQ, CAPT.
- IDLE:
  - ioctl_rd && active && ioctl_addr<MEM_SIZE → REQ. mem_addr latched from ioctl_addr[MEM_AW-1:0]; mem_req=1 and ioctl_wait=1 from the next cycle.
  - ioctl_rd && active && ioctl_addr>=MEM_SIZE → stay IDLE. ioctl_din=FILL next cycle, no wait, no RAM access. Counted as delivered (byte_count+1, checksum+=FILL).
  - ioctl_rd && !active → ignored; nothing changes.
- REQ: mem_req held high and mem_addr stable. On the accept cycle (mem_gnt=1) → CAPT and mem_req drops the following cycle. No timeout: a CPU holding the port stalls indefinitely.
- CAPT: latch mem_q into ioctl_din; byte_count+1; checksum+=mem_q mod 256; ioctl_wait=0 and → IDLE, all on the same edge.
- Latency: with an immediate grant, ioctl_din is valid 3 cycles after the ioctl_rd cycle, and ioctl_wait is high for exactly 2 cycles. Each extra cycle of grant denial adds 1 cycle to both.
- ioctl_din holds its value until the next delivered byte.
- ioctl_rd while busy → request ignored, proto_err=1 (sticky until the next session start or reset).
- ioctl_rd in the same cycle CAPT completes counts as busy: the request is ignored and proto_err is set.
- byte_count wraps at 2^25; checksum wraps at 256.

Decomposition:
- Shared package cart_ram_pkg holds:
  - FSM state enum (IDLE, REQ, CAPT).
  - MEM_AW/MEM_SIZE defaults.
  - UPLOAD_INDEX and the download index, so the writer and reader paths agree.
- No sub-module. The fetch FSM and the session/statistics logic stay in one module.

Test Plan:
- Single in-range read, grant tied high: RAM[0x010]=0x5A, upload index 1, rd@addr 0x10 at T → mem_req at T+1, ioctl_wait high T+1..T+2, ioctl_din=0x5A at T+3; byte_count=1, checksum=0x5A.
- Grant denied 4 cycles: rd@addr 0x7FF with RAM=0xC3 → mem_req held for 5 cycles, ioctl_wait high for 6, ioctl_din=0xC3; mem_addr stable throughout.
- Out-of-range: rd@addr 0x800 → ioctl_din=0xFF next cycle, ioctl_wait never high, mem_req never high, byte_count+1.
- Session statistics: 256 sequential reads of RAM filled with value=addr[7:0], then drop ioctl_upload → byte_count=256, checksum=0x80, done pulses exactly once; a new session clears both counters to 0.
- Abort and reset: drop ioctl_upload while in REQ → IDLE next cycle, mem_req and ioctl_wait low, byte not counted. Separately, reset_n low for one cycle mid-CAPT → all outputs at reset values, ioctl_din=0xFF.
- Protocol violation and wrong index: rd during REQ → proto_err=1, original fetch completes normally. rd with ioctl_index=0 → no response, no counter change.

Source files
------------

// File: rtl/cart_ram_pkg.sv
// Shared definitions for the cartridge RAM download writer and upload reader paths.
// Both paths take their file index from here so they always agree.
package cart_ram_pkg;

    localparam int         MEM_AW_DEF       = 11;
    localparam int         MEM_SIZE_DEF     = 2048;
    localparam logic [7:0] FILL_DEF         = 8'hFF;

    // The cartridge image is downloaded and uploaded through the same menu slot.
    localparam logic [7:0] CART_INDEX       = 8'h01;
    localparam logic [7:0] DOWNLOAD_INDEX   = CART_INDEX;
    localparam logic [7:0] UPLOAD_INDEX_DEF = CART_INDEX;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_CAPT = 2'd2
    } fetch_state_e;

endpackage

// File: rtl/cart_ram_uploader_if.sv
// Arbitrated byte-wide read port of the shared cartridge/work RAM.
// master = requester (uploader), slave = arbiter/RAM side.
interface cart_ram_uploader_if
    import cart_ram_pkg::*;
#(
    parameter int MEM_AW = MEM_AW_DEF
);

    logic              req;
    logic [MEM_AW-1:0] addr;
    logic              gnt;
    logic [7:0]        q;

    modport master (output req, output addr, input gnt, input q);
    modport slave  (input req, input addr, output gnt, output q);

endinterface

// File: rtl/cart_ram_uploader.sv
// HPS ioctl upload responder: fetches each requested byte from the shared RAM
// read port, stalls hps_io while the fetch is pending, and keeps session statistics.
module cart_ram_uploader
    import cart_ram_pkg::*;
#(
    parameter int         MEM_AW       = MEM_AW_DEF,
    parameter int         MEM_SIZE     = MEM_SIZE_DEF,
    parameter logic [7:0] UPLOAD_INDEX = UPLOAD_INDEX_DEF,
    parameter logic [7:0] FILL         = FILL_DEF
) (
    input  logic                clk_sys,
    input  logic                reset_n,

    input  logic                ioctl_upload,
    input  logic [7:0]          ioctl_index,
    input  logic                ioctl_rd,
    input  logic [24:0]         ioctl_addr,
    output logic [7:0]          ioctl_din,
    output logic                ioctl_wait,

    cart_ram_uploader_if.master mem,

    output logic                busy,
    output logic                done,
    output logic [24:0]         byte_count,
    output logic [7:0]          checksum,
    output logic                proto_err
);

    fetch_state_e      r_state;
    fetch_state_e      w_state_nxt;

    logic              r_active_d;
    logic              r_done;
    logic              r_proto_err;
    logic [7:0]        r_din;
    logic [7:0]        r_checksum;
    logic [24:0]       r_byte_count;
    logic [MEM_AW-1:0] r_mem_addr;

    logic              w_active;
    logic              w_rise;
    logic              w_fall;
    logic              w_busy;
    logic              w_in_range;
    logic              w_start;
    logic              w_oor;
    logic              w_capt;
    logic              w_deliver;
    logic [7:0]        w_byte;
    logic [24:0]       w_count_base;
    logic [7:0]        w_sum_base;

    assign w_active   = ioctl_upload && (ioctl_index == UPLOAD_INDEX);
    assign w_rise     = w_active && !r_active_d;
    assign w_fall     = !w_active && r_active_d;
    assign w_busy     = (r_state != ST_IDLE);
    assign w_in_range = (ioctl_addr < 25'(MEM_SIZE));

    assign w_start    = (r_state == ST_IDLE) && ioctl_rd && w_active && w_in_range;
    assign w_oor      = (r_state == ST_IDLE) && ioctl_rd && w_active && !w_in_range;
    // A session ending in the capture cycle aborts the byte rather than counting it.
    assign w_capt     = (r_state == ST_CAPT) && !w_fall;
    assign w_deliver  = w_oor || w_capt;
    assign w_byte     = w_capt ? mem.q : FILL;

    assign w_count_base = w_rise ? '0 : r_byte_count;
    assign w_sum_base   = w_rise ? '0 : r_checksum;

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: if (w_start)  w_state_nxt = ST_REQ;
            ST_REQ:  if (mem.gnt)  w_state_nxt = ST_CAPT;
            ST_CAPT:               w_state_nxt = ST_IDLE;
            default:               w_state_nxt = ST_IDLE;
        endcase
        if (w_fall) w_state_nxt = ST_IDLE;
    end

    // NOTE: reset is sampled inside the clocked block, so it only takes effect on an edge.
    always_ff @(posedge clk_sys) begin
        if (!reset_n) r_state <= ST_IDLE;
        else          r_state <= w_state_nxt;
    end

    // NOTE: all state below uses non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge clk_sys) begin
        if (!reset_n) begin
            r_active_d   <= 1'b0;
            r_done       <= 1'b0;
            r_proto_err  <= 1'b0;
            r_din        <= FILL;
            r_checksum   <= '0;
            r_byte_count <= '0;
            r_mem_addr   <= '0;
        end else begin
            r_active_d  <= w_active;
            r_done      <= w_fall;
            r_proto_err <= (w_rise ? 1'b0 : r_proto_err) | (ioctl_rd && w_busy);

            if (w_deliver) begin
                r_din        <= w_byte;
                r_byte_count <= w_count_base + 25'd1;
                r_checksum   <= w_sum_base + w_byte;
            end else begin
                r_byte_count <= w_count_base;
                r_checksum   <= w_sum_base;
            end

            if (w_start) r_mem_addr <= ioctl_addr[MEM_AW-1:0];
        end
    end

    assign mem.req    = (r_state == ST_REQ);
    assign mem.addr   = r_mem_addr;
    assign ioctl_wait = w_busy;
    assign ioctl_din  = r_din;
    assign busy       = w_busy;
    assign done       = r_done;
    assign byte_count = r_byte_count;
    assign checksum   = r_checksum;
    assign proto_err  = r_proto_err;

endmodule

// File: tb/tb_cart_ram_uploader.sv
// Self-checking bench: transaction-level model of the uploader compared every cycle,
// plus directed scenarios with hand-computed expectations and a randomized soak.
module tb_cart_ram_uploader;
    import cart_ram_pkg::*;

    localparam int AW   = 11;
    localparam int SIZE = 2048;

    logic        clk_sys      = 1'b0;
    logic        reset_n      = 1'b0;
    logic        ioctl_upload = 1'b0;
    logic [7:0]  ioctl_index  = 8'h00;
    logic        ioctl_rd     = 1'b0;
    logic [24:0] ioctl_addr   = '0;
    logic [7:0]  ioctl_din;
    logic        ioctl_wait;
    logic        busy;
    logic        done;
    logic [24:0] byte_count;
    logic [7:0]  checksum;
    logic        proto_err;

    cart_ram_uploader_if #(.MEM_AW(AW)) mem_if ();

    cart_ram_uploader #(
        .MEM_AW      (AW),
        .MEM_SIZE    (SIZE),
        .UPLOAD_INDEX(8'h01),
        .FILL        (8'hFF)
    ) dut (
        .clk_sys     (clk_sys),
        .reset_n     (reset_n),
        .ioctl_upload(ioctl_upload),
        .ioctl_index (ioctl_index),
        .ioctl_rd    (ioctl_rd),
        .ioctl_addr  (ioctl_addr),
        .ioctl_din   (ioctl_din),
        .ioctl_wait  (ioctl_wait),
        .mem         (mem_if),
        .busy        (busy),
        .done        (done),
        .byte_count  (byte_count),
        .checksum    (checksum),
        .proto_err   (proto_err)
    );

    always #5 clk_sys = ~clk_sys;

    int n_checks = 0;
    int n_errors = 0;
    bit chk_en   = 1'b0;

    logic [7:0] ram [SIZE];

    initial mem_if.gnt = 1'b0;

    // RAM data is valid only in the cycle after an accept; garbage otherwise.
    always @(posedge clk_sys) begin
        if (mem_if.req && mem_if.gnt) mem_if.q <= ram[mem_if.addr];
        else                          mem_if.q <= 8'($urandom);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: a fetch is either absent, waiting for a grant, or granted and landing next edge.
    bit          m_act;
    bit          m_prev;
    bit          m_pend;
    bit          m_gntd;
    bit          m_done;
    bit          m_proto;
    logic [7:0]  m_din;
    logic [7:0]  m_sum;
    logic [7:0]  m_byte;
    logic [24:0] m_count;
    logic [AW-1:0] m_addr;

    always @(posedge clk_sys) begin
        m_act = ioctl_upload && (ioctl_index == 8'h01);
        if (!reset_n) begin
            m_prev = 0; m_pend = 0; m_gntd = 0; m_done = 0; m_proto = 0;
            m_din = 8'hFF; m_sum = 0; m_count = 0; m_addr = 0;
        end else begin
            m_done = m_prev && !m_act;
            if (m_act && !m_prev) begin
                m_count = 0; m_sum = 0; m_proto = 0;
            end
            if (ioctl_rd && m_pend) m_proto = 1;
            if (m_pend && !m_act) begin
                m_pend = 0;
            end else if (m_pend && m_gntd) begin
                m_din = m_byte; m_count = m_count + 1; m_sum = m_sum + m_byte;
                m_pend = 0;
            end else if (m_pend) begin
                if (mem_if.gnt) begin
                    m_gntd = 1; m_byte = ram[m_addr];
                end
            end else if (ioctl_rd && m_act) begin
                if (ioctl_addr < SIZE) begin
                    m_pend = 1; m_gntd = 0; m_addr = ioctl_addr[AW-1:0];
                end else begin
                    m_din = 8'hFF; m_count = m_count + 1; m_sum = m_sum + 8'hFF;
                end
            end
            m_prev = m_act;
        end
        chk_en = 1'b1;
    end

    always @(negedge clk_sys) begin
        if (chk_en) begin
            check("din",      ioctl_din,   m_din);
            check("wait",     ioctl_wait,  m_pend);
            check("mem_req",  mem_if.req,  m_pend && !m_gntd);
            check("busy",     busy,        m_pend);
            check("mem_addr", mem_if.addr, m_addr);
            check("done",     done,        m_done);
            check("count",    byte_count,  m_count);
            check("checksum", checksum,    m_sum);
            check("proto",    proto_err,   m_proto);
        end
    end

    task automatic tick();
        @(posedge clk_sys);
        #1;
    endtask

    task automatic wait_idle(input int budget);
        int k = 0;
        while (ioctl_wait === 1'b1 && k < budget) begin
            tick();
            k++;
        end
        check("wait_bound", ioctl_wait, 1'b0);
    endtask

    task automatic start_session();
        ioctl_upload = 1'b0;
        tick();
        ioctl_upload = 1'b1;
        ioctl_index  = 8'h01;
        tick();
    endtask

    task automatic issue_rd(input int addr);
        ioctl_rd   = 1'b1;
        ioctl_addr = 25'(addr);
        tick();
        ioctl_rd   = 1'b0;
    endtask

    initial begin
        int req_cnt;
        int wait_cnt;
        int done_cnt;
        logic [24:0] cnt0;

        for (int i = 0; i < SIZE; i++) ram[i] = 8'($urandom);

        tick();
        tick();
        check("rst_din",   ioctl_din,  8'hFF);
        check("rst_wait",  ioctl_wait, 1'b0);
        check("rst_req",   mem_if.req, 1'b0);
        check("rst_count", byte_count, 25'd0);
        reset_n = 1'b1;
        tick();

        // Single in-range read, grant tied high.
        ram[11'h010] = 8'h5A;
        mem_if.gnt   = 1'b1;
        start_session();
        issue_rd(32'h10);
        check("t1_req_t1",  mem_if.req, 1'b1);
        check("t1_wait_t1", ioctl_wait, 1'b1);
        tick();
        check("t1_wait_t2", ioctl_wait, 1'b1);
        check("t1_req_t2",  mem_if.req, 1'b0);
        tick();
        check("t1_wait_t3", ioctl_wait, 1'b0);
        check("t1_din",     ioctl_din,  8'h5A);
        check("t1_count",   byte_count, 25'd1);
        check("t1_sum",     checksum,   8'h5A);

        // Grant denied for four cycles.
        ram[11'h7FF] = 8'hC3;
        mem_if.gnt   = 1'b0;
        issue_rd(32'h7FF);
        req_cnt  = 0;
        wait_cnt = 0;
        for (int i = 0; i < 10; i++) begin
            if (mem_if.req === 1'b1) begin
                req_cnt++;
                check("t2_addr_stable", mem_if.addr, 11'h7FF);
            end
            if (ioctl_wait === 1'b1) wait_cnt++;
            if (i == 4) mem_if.gnt = 1'b1;
            tick();
        end
        check("t2_req_cycles",  req_cnt,   5);
        check("t2_wait_cycles", wait_cnt,  6);
        check("t2_din",         ioctl_din, 8'hC3);

        // Out-of-range address returns FILL with no RAM access.
        cnt0 = byte_count;
        issue_rd(32'h800);
        check("t3_din",   ioctl_din,  8'hFF);
        check("t3_wait",  ioctl_wait, 1'b0);
        check("t3_req",   mem_if.req, 1'b0);
        check("t3_count", byte_count, cnt0 + 25'd1);
        tick();
        check("t3_req_after", mem_if.req, 1'b0);

        // 256 sequential reads, then end the session.
        for (int i = 0; i < 256; i++) ram[i] = 8'(i);
        start_session();
        for (int a = 0; a < 256; a++) begin
            issue_rd(a);
            wait_idle(20);
        end
        ioctl_upload = 1'b0;
        done_cnt = 0;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (done === 1'b1) done_cnt++;
        end
        check("t4_done_once", done_cnt,   1);
        check("t4_count",     byte_count, 25'd256);
        check("t4_sum",       checksum,   8'h80);
        ioctl_upload = 1'b1;
        tick();
        check("t4_new_count", byte_count, 25'd0);
        check("t4_new_sum",   checksum,   8'h00);

        // Abort while waiting for a grant.
        mem_if.gnt = 1'b0;
        cnt0 = byte_count;
        issue_rd(5);
        check("t5_req", mem_if.req, 1'b1);
        ioctl_upload = 1'b0;
        tick();
        check("t5_abort_req",  mem_if.req, 1'b0);
        check("t5_abort_wait", ioctl_wait, 1'b0);
        mem_if.gnt = 1'b1;
        tick();
        tick();
        check("t5_abort_count", byte_count, cnt0);
        check("t5_late_gnt",    ioctl_wait, 1'b0);

        // Reset during the capture cycle.
        start_session();
        issue_rd(32'h10);
        tick();
        check("t5_in_capt", ioctl_wait, 1'b1);
        reset_n = 1'b0;
        tick();
        check("t5_rst_din",   ioctl_din,  8'hFF);
        check("t5_rst_wait",  ioctl_wait, 1'b0);
        check("t5_rst_req",   mem_if.req, 1'b0);
        check("t5_rst_count", byte_count, 25'd0);
        check("t5_rst_sum",   checksum,   8'h00);
        reset_n = 1'b1;
        tick();

        // Request while busy, then a request for another index.
        start_session();
        mem_if.gnt = 1'b0;
        ioctl_rd   = 1'b1;
        ioctl_addr = 25'h20;
        tick();
        ioctl_addr = 25'h30;
        tick();
        ioctl_rd = 1'b0;
        check("t6_proto", proto_err, 1'b1);
        mem_if.gnt = 1'b1;
        wait_idle(10);
        check("t6_din",  ioctl_din,   8'h20);
        check("t6_addr", mem_if.addr, 11'h020);
        cnt0 = byte_count;
        ioctl_index = 8'h00;
        issue_rd(32'h40);
        check("t6_idx_wait", ioctl_wait, 1'b0);
        check("t6_idx_req",  mem_if.req, 1'b0);
        tick();
        check("t6_idx_count", byte_count, cnt0);
        check("t6_idx_din",   ioctl_din,  8'h20);
        check("t6_sticky",    proto_err,  1'b1);
        ioctl_index = 8'h01;

        // Randomized soak against the model.
        for (int i = 0; i < SIZE; i++) ram[i] = 8'($urandom);
        for (int c = 0; c < 3000; c++) begin
            reset_n      = ($urandom_range(0, 199) != 0);
            if ($urandom_range(0, 59) == 0) ioctl_upload = ~ioctl_upload;
            ioctl_index  = ($urandom_range(0, 19) != 0) ? 8'h01 : 8'($urandom_range(0, 3));
            ioctl_rd     = ($urandom_range(0, 3) == 0);
            ioctl_addr   = ($urandom_range(0, 7) == 0) ? 25'(SIZE + $urandom_range(0, 99))
                                                       : 25'($urandom_range(0, SIZE - 1));
            mem_if.gnt   = ($urandom_range(0, 2) != 0);
            tick();
        end
        ioctl_rd = 1'b0;
        reset_n  = 1'b1;
        tick();
        tick();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
